req_xbar_core: RTL
==================

// Module: req_xbar_core
// PURPOSE
//   Request-direction crossbar of the memory path: routes requests from NUM_CH upstream channels to
//   NUM_BANK downstream banks. Each bank port has a round-robin arbiter and a 2-entry output FIFO.
//   The winning channel id is forwarded with the request. The bank echoes it on its response path
//   so the return crossbar can steer data back to that channel.
// PARAMETERS
//   NUM_CH    3    number of upstream channels
//   NUM_BANK  4    number of downstream banks
//   ADDR_W    32   request address width
//   DATA_W    128  write data width
//   CH_W      $clog2(NUM_CH)=2, BK_W = $clog2(NUM_BANK)=2 (derived, localparam)
// PORTS
//   clk                  in   1                  clock, all logic rising-edge
//   rst                  in   1                  asynchronous, active-high reset
//   u_ch_req_valid       in   [NUM_CH]           channel c request valid
//   u_ch_req_ready       out  [NUM_CH]           channel c request accepted this cycle
//   u_ch_req_bank_id     in   [NUM_CH][BK_W]     target bank of channel c
//   u_ch_req_we          in   [NUM_CH]           1=write, 0=read
//   u_ch_req_addr        in   [NUM_CH][ADDR_W]   bank-local address
//   u_ch_req_data        in   [NUM_CH][DATA_W]   write data (don't-care for reads)
//   d_bank_req_valid     out  [NUM_BANK]         bank b FIFO head valid
//   d_bank_req_ready     in   [NUM_BANK]         bank b accepts head
//   d_bank_req_we        out  [NUM_BANK]         head we
//   d_bank_req_addr      out  [NUM_BANK][ADDR_W] head address
//   d_bank_req_data      out  [NUM_BANK][DATA_W] head write data
//   d_bank_req_ch_id     out  [NUM_BANK][CH_W]   originating channel of head
// BEHAVIOUR
//   - Reset (rst=1, async): all FIFOs empty, all RR pointers 0. d_bank_req_valid=0,
//     u_ch_req_ready=0, all d_bank payload outputs 0.
//   - Request vector of bank b: req_b[c] = u_ch_req_valid[c] && (u_ch_req_bank_id[c]==b).
//   - Arbitration: grant goes to the first c with req_b[c]=1, searching c = ptr_b, ptr_b+1, ...
//     wrapping mod NUM_CH. The grant is one-hot or zero.
//   - Ready: u_ch_req_ready[c] = grant_b[c] && !full_b, where b = u_ch_req_bank_id[c].
//     Ready may depend on valid. The channel holds valid and payload stable until ready.
//   - Push: when any(grant_b) && !full_b. Payload {we, addr, data, ch_id=c} is written at the tail
//     and ptr_b <= (c+1) % NUM_CH. ptr_b is unchanged when there is no push.
//   - full_b depends on registered count only (count==2). d_bank_req_ready has no combinational
//     path to u_ch_req_ready. If full and a pop happens in the same cycle, there is no push.
//   - Pop: when d_bank_req_valid[b] && d_bank_req_ready[b]. d_bank_req_valid[b] = (count_b != 0).
//     The payload outputs are driven from the head entry (registered).
//   - Push and pop in the same cycle with count 1: count stays 1, new entry becomes head next cycle.
//   - Latency: a request accepted in cycle N appears at the bank in cycle N+1 if the FIFO was empty.
//   - Per-channel ordering: requests from one channel to one bank are delivered in acceptance order.
//     Requests to different banks are not ordered relative to each other.
//   - Bank id >= NUM_BANK: the request is never granted (u_ch_req_ready stays 0). This is a
//     protocol violation; the assertion below flags it.
//   - Reset asserted mid-transfer: in-flight FIFO contents are discarded and no valid survives.
// STRUCTURE
//   - mpc_types package:
//     - NUM_CH, NUM_BANK
//     - typedef struct packed {logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;
//       logic [CH_W-1:0] ch_id;} req_payload_t
//   - Sub-module req_xbar_bank_port (RR arbiter, 2-entry FIFO, ptr), generate-instantiated
//     NUM_BANK times.
//   - Top level: request decode, OR-reduction of per-bank grants into u_ch_req_ready.
//   - SVA: u_ch_req_ready one-hot per bank; valid stable until ready; bank_id < NUM_BANK when valid.
// TESTING
//   1. Reset: rst pulse mid-traffic -> all d_bank_req_valid=0 and u_ch_req_ready=0 in the same
//      cycle; count=0 after release.
//   2. Single path: ch1 write addr 0x40, data 0xA5.., to bank2 with bank ready=1 -> ready[1]=1 in
//      cycle N; in N+1 bank2 valid=1, addr=0x40, ch_id=1, we=1.
//   3. Contention: ch0, ch1, ch2 all target bank0 continuously, ready=1 -> grant order 0,1,2,0,1,2,
//      one acceptance per cycle.
//   4. Backpressure: bank3 ready=0, ch2 streams to bank3 -> exactly 2 accepted, then ready[2]=0.
//      Raise bank ready -> entries pop in order, and the next push happens 1 cycle after count<2.
//   5. Parallelism: ch0->bank0, ch1->bank1, ch2->bank3 in the same cycle -> all three ready=1;
//      all three banks valid next cycle with correct ch_id.
//   6. Pointer wrap: ptr0=2, requests only from ch0 and ch1 -> ch0 granted first, then ch1.

Source files
------------

// File: rtl/mpc_types.sv
// Shared types and sizing for the memory-path request crossbar.
// Defines channel/bank counts, bus widths and the request payload carried through each bank FIFO.
// The helper ch_wrap_inc advances a channel index modulo NUM_CH (NUM_CH need not be a power of two).
package mpc_types;
  localparam int NUM_CH     = 3;
  localparam int NUM_BANK   = 4;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 128;
  localparam int CH_W       = $clog2(NUM_CH);
  localparam int BK_W       = $clog2(NUM_BANK);
  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   ch_id;
  } req_payload_t;

  function automatic logic [CH_W-1:0] ch_wrap_inc(input logic [CH_W-1:0] c);
    return (c == CH_W'(NUM_CH - 1)) ? '0 : c + 1'b1;
  endfunction
endpackage

// File: rtl/req_xbar_bank_port.sv
// One bank port: round-robin arbiter over all channels feeding a 2-entry FIFO toward the bank.
// Latency: a grant accepted in cycle N is at the FIFO head in N+1 when the FIFO was empty.
// Backpressure: grant_rdy is forced low while the FIFO is full; head_rdy never reaches grant_rdy.
// Ports: req_vld/ch_pl from the channels, grant_rdy back to them, head_vld/head_rdy/head_dat to the bank.
module req_xbar_bank_port
  import mpc_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req_vld,
  input  req_payload_t      ch_pl [NUM_CH],
  output logic [NUM_CH-1:0] grant_rdy,
  output logic              head_vld,
  input  logic              head_rdy,
  output req_payload_t      head_dat
);
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   win;
  logic              any_grant;
  logic              full;
  logic              push;
  req_payload_t      sel_pl;

  // Two passes: first the channels at or above the pointer, then wrap to the lowest requester.
  always_comb begin
    grant     = '0;
    win       = '0;
    any_grant = 1'b0;
    sel_pl    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!any_grant && req_vld[c] && (c >= int'(ptr_q))) begin
        grant[c]  = 1'b1;
        win       = CH_W'(c);
        sel_pl    = ch_pl[c];
        any_grant = 1'b1;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!any_grant && req_vld[c]) begin
        grant[c]  = 1'b1;
        win       = CH_W'(c);
        sel_pl    = ch_pl[c];
        any_grant = 1'b1;
      end
    end
  end

  assign push      = any_grant && !full && !rst;
  assign grant_rdy = push ? grant : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (push) begin
      ptr_d = ch_wrap_inc(win);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  sync_fifo #(
    .WIDTH($bits(req_payload_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (sel_pl),
    .pop      (head_rdy),
    .head_dat (head_dat),
    .head_vld (head_vld),
    .full     (full)
  );
endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; latency: pushed entry visible at head the cycle after push.
// Backpressure: push is ignored while full (full depends only on the registered count).
// Ports: push/push_dat write side, pop/head_dat/head_vld read side, full status; async active-high rst.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             head_vld,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign head_vld = (cnt_q != '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && head_vld;
  assign head_dat = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/req_xbar_core.sv
// Request crossbar: NUM_CH channels to NUM_BANK banks, per-bank RR arbiter + 2-entry FIFO, ch_id forwarded.
// Latency: request accepted in cycle N is presented to an empty bank in cycle N+1.
// Backpressure: u_ch_req_ready depends only on grants and registered FIFO fullness, never on d_bank_req_ready.
// Ports: u_ch_req_* upstream valid/ready channel requests; d_bank_req_* downstream per-bank valid/ready heads.
module req_xbar_core
  import mpc_types::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CH-1:0]                  u_ch_req_valid,
  output logic [NUM_CH-1:0]                  u_ch_req_ready,
  input  logic [NUM_CH-1:0][BK_W-1:0]        u_ch_req_bank_id,
  input  logic [NUM_CH-1:0]                  u_ch_req_we,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]      u_ch_req_addr,
  input  logic [NUM_CH-1:0][DATA_W-1:0]      u_ch_req_data,
  output logic [NUM_BANK-1:0]                d_bank_req_valid,
  input  logic [NUM_BANK-1:0]                d_bank_req_ready,
  output logic [NUM_BANK-1:0]                d_bank_req_we,
  output logic [NUM_BANK-1:0][ADDR_W-1:0]    d_bank_req_addr,
  output logic [NUM_BANK-1:0][DATA_W-1:0]    d_bank_req_data,
  output logic [NUM_BANK-1:0][CH_W-1:0]      d_bank_req_ch_id
);
  req_payload_t      ch_pl     [NUM_CH];
  logic [NUM_CH-1:0] bank_req  [NUM_BANK];
  logic [NUM_CH-1:0] bank_rdy  [NUM_BANK];
  req_payload_t      bank_head [NUM_BANK];

  // Each channel's payload is tagged with its own index so the winner carries its origin.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_pl[c].we    = u_ch_req_we[c];
      ch_pl[c].addr  = u_ch_req_addr[c];
      ch_pl[c].data  = u_ch_req_data[c];
      ch_pl[c].ch_id = CH_W'(c);
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        bank_req[b][c] = u_ch_req_valid[c] && (u_ch_req_bank_id[c] == BK_W'(b));
      end
    end
  end

  // A channel targets exactly one bank, so OR-ing every bank's grant yields its ready.
  always_comb begin
    u_ch_req_ready = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      u_ch_req_ready = u_ch_req_ready | bank_rdy[b];
    end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    req_xbar_bank_port u_port (
      .clk       (clk),
      .rst       (rst),
      .req_vld   (bank_req[b]),
      .ch_pl     (ch_pl),
      .grant_rdy (bank_rdy[b]),
      .head_vld  (d_bank_req_valid[b]),
      .head_rdy  (d_bank_req_ready[b]),
      .head_dat  (bank_head[b])
    );

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bank_rdy[b]));
  end

  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      d_bank_req_we[b]    = bank_head[b].we;
      d_bank_req_addr[b]  = bank_head[b].addr;
      d_bank_req_data[b]  = bank_head[b].data;
      d_bank_req_ch_id[b] = bank_head[b].ch_id;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch_sva
    a_hold_until_ready: assert property (@(posedge clk) disable iff (rst)
      u_ch_req_valid[c] && !u_ch_req_ready[c] |=> u_ch_req_valid[c]
        && $stable(u_ch_req_bank_id[c]) && $stable(u_ch_req_we[c])
        && $stable(u_ch_req_addr[c]) && $stable(u_ch_req_data[c]));
    a_bank_in_range: assert property (@(posedge clk) disable iff (rst)
      u_ch_req_valid[c] |-> (int'(u_ch_req_bank_id[c]) < NUM_BANK));
  end
endmodule
